// File: rtl/dds_cfg_pkg.sv
// Shared types and constants for the DDS key controller: FSM states, key indices,
// preset limits and default tuning words.
package dds_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    COMMIT,
    RELEASE
  } state_t;

  typedef logic [1:0] key_idx_t;

  localparam key_idx_t KEY_FUP = 2'd0;
  localparam key_idx_t KEY_FDN = 2'd1;
  localparam key_idx_t KEY_PH  = 2'd2;
  localparam key_idx_t KEY_CH  = 2'd3;

  localparam logic [2:0] FIDX_MAX = 3'd7;

  localparam int unsigned DEF_BASE_FWORD = 85899;
  localparam int unsigned DEF_PHASE_STEP = 512;

  // Lowest key index wins when several presses land in the same cycle.
  function automatic key_idx_t pick_key(input logic [3:0] p);
    if (p[0])      return KEY_FUP;
    else if (p[1]) return KEY_FDN;
    else if (p[2]) return KEY_PH;
    else           return KEY_CH;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: two-flop synchronizer, stability counter, accepted level
// and a one-cycle pulse on each accepted high-to-low transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
        press <= level & ~sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// Key-driven frequency/phase controller for the dual-channel DDS datapath.
// Optional auto-repeat on held keys is built when DDS_KEY_AUTOREPEAT_EN is defined.
module dds_key_ctrl
  import dds_cfg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FWORD_W         = 32,
  parameter int unsigned PWORD_W         = 12,
  parameter int unsigned BASE_FWORD      = DEF_BASE_FWORD,
  parameter int unsigned PHASE_STEP      = DEF_PHASE_STEP,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         key,
  output logic [FWORD_W-1:0] fwordA,
  output logic [FWORD_W-1:0] fwordB,
  output logic [PWORD_W-1:0] pwordA,
  output logic [PWORD_W-1:0] pwordB,
  output logic               ch_sel,
  output logic               updA,
  output logic               updB
);

  logic [3:0] press;
  logic [3:0] level;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .key     (key[i]),
      .level   (level[i]),
      .press   (press[i])
    );
  end

  state_t             state;
  state_t             next_state;
  key_idx_t           key_lat;
  logic               edit_ch;
  logic               changed;
  logic [2:0]         fidx_a;
  logic [2:0]         fidx_b;
  logic [2:0]         fidx_stg;
  logic [PWORD_W-1:0] pword_stg;
  logic               ch_stg;
  logic [2:0]         cur_fidx;
  logic [PWORD_W-1:0] cur_pword;
  logic               rep_fire;

  assign cur_fidx  = edit_ch ? fidx_b : fidx_a;
  assign cur_pword = edit_ch ? pwordB : pwordA;

`ifdef DDS_KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_again;
  logic             rep_held;

  assign rep_held = (key_lat != KEY_CH) && !level[key_lat];
  assign rep_fire = (state == RELEASE) && rep_held &&
                    (rep_cnt == (rep_again ? REP_W'(REPEAT_CYCLES - 1) : REP_W'(REPEAT_DELAY - 1)));

  // The first repeat waits the long delay; later ones use the short period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt   <= '0;
      rep_again <= 1'b0;
    end else if (state != RELEASE || !rep_held) begin
      rep_cnt <= '0;
      if (state == IDLE) rep_again <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_again <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|press) next_state = APPLY;
      APPLY:   next_state = COMMIT;
      COMMIT:  next_state = RELEASE;
      RELEASE: begin
        if (rep_fire)    next_state = APPLY;
        else if (&level) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_lat   <= KEY_FUP;
      edit_ch   <= 1'b0;
      changed   <= 1'b0;
      fidx_a    <= '0;
      fidx_b    <= '0;
      fidx_stg  <= '0;
      pword_stg <= '0;
      ch_stg    <= 1'b0;
      fwordA    <= FWORD_W'(BASE_FWORD);
      fwordB    <= FWORD_W'(BASE_FWORD);
      pwordA    <= '0;
      pwordB    <= '0;
      ch_sel    <= 1'b0;
      updA      <= 1'b0;
      updB      <= 1'b0;
    end else begin
      updA <= 1'b0;
      updB <= 1'b0;
      case (state)
        IDLE: begin
          if (|press) begin
            key_lat <= pick_key(press);
            edit_ch <= ch_sel;
          end
        end
        APPLY: begin
          fidx_stg  <= cur_fidx;
          pword_stg <= cur_pword;
          ch_stg    <= ch_sel;
          changed   <= 1'b0;
          case (key_lat)
            KEY_FUP: if (cur_fidx != FIDX_MAX) begin
              fidx_stg <= cur_fidx + 3'd1;
              changed  <= 1'b1;
            end
            KEY_FDN: if (cur_fidx != 3'd0) begin
              fidx_stg <= cur_fidx - 3'd1;
              changed  <= 1'b1;
            end
            KEY_PH: begin
              pword_stg <= cur_pword + PWORD_W'(PHASE_STEP);
              changed   <= 1'b1;
            end
            default: ch_stg <= ~ch_sel;
          endcase
        end
        COMMIT: begin
          ch_sel <= ch_stg;
          if (edit_ch) begin
            fidx_b <= fidx_stg;
            fwordB <= FWORD_W'(BASE_FWORD) << fidx_stg;
            pwordB <= pword_stg;
            updB   <= changed;
          end else begin
            fidx_a <= fidx_stg;
            fwordA <= FWORD_W'(BASE_FWORD) << fidx_stg;
            pwordA <= pword_stg;
            updA   <= changed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed self-checking bench for dds_key_ctrl with short debounce/repeat timing.
module tb_dds_key_ctrl;
  import dds_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  key = 4'hf;
  logic [31:0] fwordA, fwordB;
  logic [11:0] pwordA, pwordB;
  logic        ch_sel, updA, updB;

  int total = 0;
  int bad = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int cnt_p1 = 0;

  dds_key_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .FWORD_W         (32),
    .PWORD_W         (12),
    .BASE_FWORD      (85899),
    .PHASE_STEP      (512),
    .REPEAT_DELAY    (100),
    .REPEAT_CYCLES   (20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .fwordA  (fwordA),
    .fwordB  (fwordB),
    .pwordA  (pwordA),
    .pwordB  (pwordB),
    .ch_sel  (ch_sel),
    .updA    (updA),
    .updB    (updB)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_a  <= 0;
      cnt_b  <= 0;
      cnt_p1 <= 0;
    end else begin
      if (updA) cnt_a <= cnt_a + 1;
      if (updB) cnt_b <= cnt_b + 1;
      if (dut.press[1]) cnt_p1 <= cnt_p1 + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    key     = 4'hf;
    reset_n = 1'b0;
    hold(3);
    reset_n = 1'b1;
    hold(3);
  endtask

  task automatic press_key(input int idx);
    key[idx] = 1'b0;
    hold(40);
    key[idx] = 1'b1;
    hold(40);
  endtask

  initial begin
    logic found;

    // Reset state with idle keys
    do_reset();
    hold(30);
    check("rst_fwordA", fwordA, 85899);
    check("rst_fwordB", fwordB, 85899);
    check("rst_pwordA", pwordA, 0);
    check("rst_pwordB", pwordB, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_upd", cnt_a + cnt_b, 0);

    // Three clean frequency-up presses on channel A
    for (int i = 0; i < 3; i++) press_key(0);
    check("fup3_fwordA", fwordA, 687192);
    check("fup3_updA", cnt_a, 3);
    check("fup3_fwordB", fwordB, 85899);
    check("fup3_updB", cnt_b, 0);

    // Ten presses saturate at preset 7 with only seven updates
    do_reset();
    for (int i = 0; i < 10; i++) press_key(0);
    check("fsat_fwordA", fwordA, 10995072);
    check("fsat_updA", cnt_a, 7);

    // Switch to B, then nine phase steps wrap to 512
    do_reset();
    press_key(3);
    check("ch_toggle", ch_sel, 1);
    check("ch_no_upd", cnt_a + cnt_b, 0);
    for (int i = 0; i < 9; i++) press_key(2);
    check("ph_pwordB", pwordB, 512);
    check("ph_updB", cnt_b, 9);
    check("ph_pwordA", pwordA, 0);
    check("ph_updA", cnt_a, 0);
    check("ph_fwordB", fwordB, 85899);

    // Bouncing frequency-down: short pulses never press, stable low presses once
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key[1] = 1'b0;
      hold(10);
      key[1] = 1'b1;
      hold(10);
    end
    check("bounce_no_press", cnt_p1, 0);
    key[1] = 1'b0;
    hold(40);
    key[1] = 1'b1;
    hold(40);
    check("bounce_one_press", cnt_p1, 1);
    check("fdn_sat_fwordA", fwordA, 85899);
    check("fdn_sat_upd", cnt_a + cnt_b, 0);

    // Simultaneous up and down: only up is applied
    do_reset();
    key = 4'b1100;
    hold(40);
    key = 4'hf;
    hold(40);
    check("simul_fwordA", fwordA, 171798);
    check("simul_updA", cnt_a, 1);
    check("simul_pwordA", pwordA, 0);

    // Reset asserted while in APPLY aborts the edit immediately
    key[0] = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.state == APPLY) found = 1'b1;
    end
    check("apply_reached", found, 1);
    reset_n = 1'b0;
    #1;
    check("async_fwordA", fwordA, 85899);
    check("async_updA", updA, 0);
    check("async_ch_sel", ch_sel, 0);
    hold(2);
    reset_n = 1'b1;
    hold(5);
    check("held_not_yet", fwordA, 85899);
    hold(40);
    check("held_reaccept", fwordA, 171798);
    check("held_updA", cnt_a, 1);
    key = 4'hf;
    hold(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dds_key_ctrl.md
# dds_key_ctrl

Key-driven configuration controller for the dual-channel DDS/AD9767 datapath. It debounces the four active-low board keys and runs a small command FSM. The FSM maintains the frequency and phase words for channels A and B and emits one-cycle update strobes that the DDS cores use to latch new settings. It sits between the `key[3:0]` pins and the two DDS phase accumulators, replacing direct key wiring in the top level.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000 — consecutive stable cycles required to accept a key level (20 ms at 50 MHz).
- `FWORD_W`, 32 — frequency word width.
- `PWORD_W`, 12 — phase word width (ROM address width).
- `BASE_FWORD`, 85899 — frequency word for preset 0 (1 kHz at 50 MHz).
- `PHASE_STEP`, 512 — phase increment per key press (1/8 turn).
- `REPEAT_DELAY` and `REPEAT_CYCLES`, 25_000_000 and 5_000_000 — auto-repeat timing; used only under `DDS_KEY_AUTOREPEAT_EN`.

Ports:
- `clk` in 1 — system clock. One clock only.
- `reset_n` in 1 — asynchronous, active-low reset.
- `key` in 4 — raw keys, active-low, asynchronous to `clk`. Idle value is 4'b1111.
- `fwordA` out FWORD_W — channel A frequency word.
- `fwordB` out FWORD_W — channel B frequency word.
- `pwordA` out PWORD_W — channel A phase offset.
- `pwordB` out PWORD_W — channel B phase offset.
- `ch_sel` out 1 — channel being edited: 0 = A, 1 = B.
- `updA` out 1 — one-cycle pulse when A words change.
- `updB` out 1 — one-cycle pulse when B words change.

## Operation
- Key functions: `key[0]` = frequency up, `key[1]` = frequency down, `key[2]` = phase step, `key[3]` = toggle `ch_sel`.
- Per-key debouncer:
  - Two-flop synchronizer feeding a stability counter.
  - Accepted level changes only after `DEBOUNCE_CYCLES` identical samples.
  - A high→low accepted transition produces `press[i]`, a one-cycle pulse.
- Frequency: per-channel preset index `fidx`, 3 bits, range 0..7. `fword = BASE_FWORD << fidx`.
  - Up saturates at 7. Down saturates at 0. A saturated press does not pulse `upd`.
- Phase: `pword <= pword + PHASE_STEP`, mod 2^PWORD_W (wraps silently). Pulses `upd`.
- `ch_sel` toggle changes no words and pulses neither `upd`.
- FSM states:
  - IDLE: wait for any `press`. Latch the highest-priority pressed key (key[0] > key[1] > key[2] > key[3]); discard other simultaneous presses. Go to APPLY.
  - APPLY: compute the next `fidx`/`pword`/`ch_sel` into staging registers. Go to COMMIT.
  - COMMIT: write the outputs. Pulse `updA` or `updB` for the edited channel if its value changed. Go to RELEASE.
  - RELEASE: wait until every debounced key is high, then go to IDLE. Presses during RELEASE are ignored.
- Edits apply to the channel selected at the time of the press.
- Reset state, asserted asynchronously:
  - `fidx` = 0 for both channels, so `fwordA` = `fwordB` = BASE_FWORD.
  - `pwordA` = `pwordB` = 0.
  - `ch_sel` = 0; `updA` = `updB` = 0.
  - FSM = IDLE; debouncers hold accepted level high with counters cleared.
- Reset mid-operation aborts any press. A key still held low after reset release must be re-accepted (full debounce) before it acts.

## Timing
- Raw key edge to `press` pulse: 2 sync cycles + `DEBOUNCE_CYCLES`.
- `press` (cycle N): IDLE→APPLY at N+1, COMMIT at N+2. New outputs and `upd` pulse are visible at N+3.
- `upd` is high for exactly one cycle, coincident with the first cycle the new word is valid.
- Outputs are registered, with no combinational path from `key`.
- Bounces shorter than `DEBOUNCE_CYCLES` restart the counter and never generate `press`.

## Configuration
- `DDS_KEY_AUTOREPEAT_EN` defined:
  - In RELEASE, if the latched key is `key[0]`, `key[1]` or `key[2]` and is still held for `REPEAT_DELAY` cycles, re-enter APPLY. Repeat every `REPEAT_CYCLES` while held.
  - Saturation rules still apply.
  - `key[3]` never repeats.
- Undefined: RELEASE only waits for release. Repeat counters and parameters are unused and not synthesized.

## Structure
- Package `dds_cfg_pkg` holds:
  - FSM state enum (IDLE, APPLY, COMMIT, RELEASE);
  - key index constants (KEY_FUP, KEY_FDN, KEY_PH, KEY_CH);
  - `FIDX_MAX` = 7;
  - default `BASE_FWORD`/`PHASE_STEP`.
- Sub-module `key_debounce` (synchronizer, counter, accepted level, press pulse), instantiated 4×.

## Test plan
Benches use `DEBOUNCE_CYCLES` = 16, `REPEAT_DELAY` = 100, `REPEAT_CYCLES` = 20.
- Reset then idle keys 4'b1111 → `fwordA` = `fwordB` = 85899, `pwordA` = `pwordB` = 0, `ch_sel` = 0, no `upd` pulses.
- `key[0]` pressed 3 times (clean) → `fwordA` = 85899<<3 = 687192, three `updA` pulses, `fwordB` unchanged.
- `key[0]` pressed 10 times → `fwordA` = 85899<<7, exactly 7 `updA` pulses.
- `key[3]` then `key[2]` ×9 → `ch_sel` = 1, `pwordB` = 512 (9×512 mod 4096), 9 `updB` pulses, `pwordA` = 0.
- `key[1]` bounce of 10-cycle pulses, then stable low → one `press` only, counted after the last bounce. `fidx` saturates at 0, no `upd`.
- `key[0]` and `key[1]` low in the same cycle → only frequency-up applied. Assert `reset_n` in APPLY → outputs return to reset values immediately.
